// File: rtl/effects_chain.sv
// Multichannel guitar-style effects chain: saturating drive followed by a feedback echo
// built on one synchronous-read delay RAM per channel, with a CLEAR/RUN flush controller.
module effects_chain #(
    parameter int RESOLUTION = 24,
    parameter int CHANNELS   = 2,
    parameter int DEPTH      = 4096
) (
    input  logic                           data_CLK,
    input  logic                           reset,
    input  logic [9:0]                     SW,
    input  logic                           in_valid,
    input  logic [CHANNELS*RESOLUTION-1:0] data_in,
    output logic                           out_valid,
    output logic [CHANNELS*RESOLUTION-1:0] data_out,
    output logic [CHANNELS-1:0]            clip_flag,
    output logic                           clearing
);
    localparam int R  = RESOLUTION;
    localparam int W  = CHANNELS * RESOLUTION;
    localparam int AW = $clog2(DEPTH);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam logic signed [R-1:0] SAT_MAX = {1'b0, {(R-1){1'b1}}};
    localparam logic signed [R-1:0] SAT_MIN = {1'b1, {(R-1){1'b0}}};

    logic [0:0]          state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [AW-1:0]       s_q, s_d;
    logic [2:0]          sw_dly_q, sw_dly_d;
    logic                sw_seen_q, sw_seen_d;

    logic                s1_valid_q, s1_valid_d;
    logic [W-1:0]        s1_x_q, s1_x_d;
    logic [AW-1:0]       s1_slot_q, s1_slot_d;
    logic                s1_clr_q, s1_clr_d;

    logic                out_valid_q, out_valid_d;
    logic [W-1:0]        data_out_q, data_out_d;
    logic [CHANNELS-1:0] clip_q, clip_d;

    logic [2:0]          drv_k;
    logic [2:0]          echo_f;
    logic [AW:0]         delay;
    logic [AW-1:0]       rd_addr;
    logic [AW-1:0]       mem_waddr;
    logic                mem_we;
    logic                echo_en;

    wire  [W-1:0]        y_all;
    wire  [CHANNELS-1:0] sat_all;
    wire                 unused_sw = SW[9];

    assign clearing  = (state_q == ST_CLEAR);
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign clip_flag = clip_q;

    always_comb begin
        drv_k     = {1'b0, SW[2:1]} + 3'd1;
        echo_f    = {1'b0, SW[8:7]} + 3'd1;
        delay     = (AW+1)'(DEPTH) >> SW[6:4];
        // A full-depth delay truncates to zero, i.e. the slot itself one lap ago.
        rd_addr   = s_q - delay[AW-1:0];
        // Samples accepted or finished while flushing are kept dry and never stored.
        echo_en   = SW[3] & ~clearing & ~s1_clr_q;
        mem_we    = clearing | (s1_valid_q & ~s1_clr_q);
        mem_waddr = clearing ? cnt_q : s1_slot_q;
    end

    // NOTE: every variable assigned in an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sw_dly_d  = SW[6:4];
        sw_seen_d = 1'b1;
        if (sw_seen_q && (SW[6:4] != sw_dly_q)) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end else if (state_q == ST_CLEAR) begin
            if (cnt_q == AW'(DEPTH - 1)) begin
                state_d = ST_RUN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        s_d        = s_q + {{(AW-1){1'b0}}, in_valid};
        s1_valid_d = in_valid;
        s1_x_d     = in_valid ? data_in : s1_x_q;
        s1_slot_d  = in_valid ? s_q : s1_slot_q;
        s1_clr_d   = clearing;

        out_valid_d = s1_valid_q;
        data_out_d  = s1_valid_q ? y_all : data_out_q;
        clip_d      = s1_valid_q ? sat_all : clip_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge data_CLK or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            s_q         <= '0;
            sw_dly_q    <= '0;
            sw_seen_q   <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_slot_q   <= '0;
            s1_clr_q    <= 1'b0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            clip_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            sw_dly_q    <= sw_dly_d;
            sw_seen_q   <= sw_seen_d;
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_slot_q   <= s1_slot_d;
            s1_clr_q    <= s1_clr_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            clip_q      <= clip_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic signed [R-1:0] mem [DEPTH];
        logic signed [R-1:0] rd_q;
        logic signed [R-1:0] x;
        logic signed [R-1:0] d;
        logic signed [R-1:0] y;
        logic signed [R-1:0] m_sh;
        logic signed [R+4:0] shl;
        logic signed [R:0]   sum;
        logic                drv_sat;
        logic                echo_sat;

        // NOTE: the delay RAM has no reset; its contents are defined only by the CLEAR sweep.
        always_ff @(posedge data_CLK) begin
            if (mem_we) begin
                mem[mem_waddr] <= clearing ? '0 : y;
            end
            if (in_valid) begin
                rd_q <= mem[rd_addr];
            end
        end

        always_comb begin
            x        = s1_x_q[c*R +: R];
            shl      = {{5{x[R-1]}}, x} <<< drv_k;
            d        = x;
            drv_sat  = 1'b0;
            if (SW[0]) begin
                d = shl[R-1:0];
                if (shl[R+4:R-1] != {6{shl[R+4]}}) begin
                    drv_sat = 1'b1;
                    d       = shl[R+4] ? SAT_MIN : SAT_MAX;
                end
            end

            m_sh     = rd_q >>> echo_f;
            sum      = {d[R-1], d} + {m_sh[R-1], m_sh};
            y        = d;
            echo_sat = 1'b0;
            if (echo_en) begin
                y = sum[R-1:0];
                if (sum[R] != sum[R-1]) begin
                    echo_sat = 1'b1;
                    y        = sum[R] ? SAT_MIN : SAT_MAX;
                end
            end
        end

        assign y_all[c*R +: R] = y;
        assign sat_all[c]      = drv_sat | echo_sat;
    end

endmodule

// File: tb/tb_effects_chain.sv
// Self-checking bench for effects_chain: randomized streams compared cycle by cycle
// against a slot-addressed arithmetic model of drive, echo and buffer flushing.
module tb_effects_chain;
    localparam int R     = 24;
    localparam int CH    = 2;
    localparam int DEPTH = 4096;
    localparam int W     = CH * R;
    localparam longint MAXV = (longint'(1) << (R - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (R - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [9:0]    sw = '0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          out_valid;
    logic [W-1:0]  data_out;
    logic [CH-1:0] clip_flag;
    logic          clearing;

    always #5 clk = ~clk;

    effects_chain #(.RESOLUTION(R), .CHANNELS(CH), .DEPTH(DEPTH)) dut (
        .data_CLK  (clk),
        .reset     (rst),
        .SW        (sw),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_valid (out_valid),
        .data_out  (data_out),
        .clip_flag (clip_flag),
        .clearing  (clearing)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic signed [R-1:0] mem_m [CH][DEPTH];
    int            s_m;
    int            clr_left;
    bit            prev_ok;
    logic [2:0]    prev_dly;
    bit            a_valid;
    bit            a_clr;
    logic [W-1:0]  a_x;
    int            a_slot;
    logic [9:0]    a_sw;
    bit            b_valid;
    logic [W-1:0]  b_y;
    logic [CH-1:0] b_clip;
    int            clr_obs;
    int            ov_obs;
    longint        obs0[$];

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint sat_r(input longint v, output bit hit);
        hit = 1'b0;
        if (v > MAXV) begin
            hit = 1'b1;
            return MAXV;
        end
        if (v < MINV) begin
            hit = 1'b1;
            return MINV;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] pack(input int a, input int b);
        return {R'(b), R'(a)};
    endfunction

    function automatic int rnd_sample();
        int v;
        v = int'($urandom);
        return v >>> ($urandom_range(16, 8));
    endfunction

    task automatic zero_model();
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < DEPTH; i++)
                mem_m[c][i] = '0;
    endtask

    task automatic model_reset();
        s_m      = 0;
        clr_left = DEPTH;
        prev_ok  = 1'b0;
        a_valid  = 1'b0;
        b_valid  = 1'b0;
        zero_model();
    endtask

    // Result of one sample: drive, then (unless dry) echo from the slot D samples back.
    task automatic compute(input logic [W-1:0] x, input logic [9:0] s_w, input int slot,
                           input bit dry, output logic [W-1:0] y, output logic [CH-1:0] cl);
        for (int c = 0; c < CH; c++) begin
            longint xv, d, v;
            bit     h1, h2;
            int     dl, addr;
            xv = longint'($signed(x[c*R +: R]));
            h1 = 1'b0;
            h2 = 1'b0;
            d  = xv;
            if (s_w[0]) d = sat_r(xv * (longint'(1) << (s_w[2:1] + 1)), h1);
            if (!dry) begin
                dl   = DEPTH >> s_w[6:4];
                addr = (slot + DEPTH - dl) % DEPTH;
                v    = d + (longint'(mem_m[c][addr]) >>> (s_w[8:7] + 1));
                d    = sat_r(v, h2);
            end
            y[c*R +: R] = d[R-1:0];
            cl[c]       = h1 | h2;
        end
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit vld, input logic [W-1:0] x);
        bit            clr_now;
        logic [W-1:0]  y;
        logic [CH-1:0] cl;
        clr_now = (clr_left > 0);
        check("clearing", clearing, clr_now);
        check("out_valid", out_valid, b_valid);
        if (clearing) clr_obs++;
        if (out_valid) ov_obs++;
        if (b_valid) begin
            for (int c = 0; c < CH; c++)
                check($sformatf("data_out_ch%0d", c), $signed(data_out[c*R +: R]), $signed(b_y[c*R +: R]));
            check("clip_flag", clip_flag, b_clip);
            obs0.push_back(longint'($signed(data_out[R-1:0])));
        end

        b_valid = 1'b0;
        if (a_valid) begin
            compute(a_x, a_sw, a_slot, a_clr || clr_now || !a_sw[3], y, cl);
            if (!a_clr && !clr_now)
                for (int c = 0; c < CH; c++) mem_m[c][a_slot] = y[c*R +: R];
            b_valid = 1'b1;
            b_y     = y;
            b_clip  = cl;
        end

        in_valid = vld;
        data_in  = x;
        a_valid  = vld;
        a_x      = x;
        a_slot   = s_m;
        a_clr    = clr_now;
        a_sw     = sw;
        if (vld) s_m = (s_m + 1) % DEPTH;

        if (prev_ok && (sw[6:4] != prev_dly)) begin
            clr_left = DEPTH;
            zero_model();
        end else if (clr_left > 0) begin
            clr_left--;
        end
        prev_dly = sw[6:4];
        prev_ok  = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic rand_stream(input int n, input int pct_valid);
        for (int i = 0; i < n; i++)
            step(($urandom % 100) < pct_valid, pack(rnd_sample(), rnd_sample()));
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_clip", clip_flag, 0);
        rst = 1'b0;

        // Power-up flush length and quiet output
        clr_obs = 0;
        idle(4100);
        check("clear_len", clr_obs, DEPTH);
        check("clear_data_out", data_out, 0);

        // Directed drive saturation points, k=1, echo off
        sw = 10'b00_000_0_00_1;
        step(1'b1, pack(2097152, 0));
        step(1'b0, '0);
        check("drv_2097152", $signed(data_out[R-1:0]), 4194304);
        check("drv_2097152_clip", clip_flag[0], 0);
        step(1'b1, pack(5242880, 0));
        step(1'b0, '0);
        check("drv_5242880", $signed(data_out[R-1:0]), 8388607);
        check("drv_5242880_clip", clip_flag[0], 1);
        step(1'b1, pack(-5242880, 0));
        step(1'b0, '0);
        check("drv_neg5242880", $signed(data_out[R-1:0]), -8388608);
        check("drv_neg5242880_clip", clip_flag[0], 1);
        idle(2);

        // Random drive/echo settings at full delay
        for (int blk = 0; blk < 6; blk++) begin
            sw[3:0] = 4'($urandom);
            sw[8:7] = 2'($urandom);
            rand_stream(60, 70);
            idle(3);
        end

        // Latency: single pulse, then ten back to back
        ov_obs = 0;
        step(1'b1, pack(rnd_sample(), rnd_sample()));
        idle(5);
        check("single_pulse_count", ov_obs, 1);
        ov_obs = 0;
        for (int i = 0; i < 10; i++) step(1'b1, pack(rnd_sample(), rnd_sample()));
        idle(5);
        check("burst_count", ov_obs, 10);

        // Impulse echo at D=512, f=1
        sw = 10'b0_00_011_1_00_0;
        clr_obs = 0;
        idle(4100);
        check("clear_len_dly", clr_obs, DEPTH);
        obs0.delete();
        step(1'b1, pack(1048576, 0));
        for (int i = 1; i < 1030; i++) step(1'b1, '0);
        idle(3);
        check("echo_count", obs0.size(), 1030);
        if (obs0.size() == 1030) begin
            check("echo_s0", obs0[0], 1048576);
            check("echo_s511", obs0[511], 0);
            check("echo_s512", obs0[512], 524288);
            check("echo_s513", obs0[513], 0);
            check("echo_s1024", obs0[1024], 262144);
        end

        // Random echo with short delays
        for (int rnd = 0; rnd < 2; rnd++) begin
            sw[6:4] = 3'(4 + rnd * 3);
            idle(4100);
            for (int blk = 0; blk < 10; blk++) begin
                sw[3]   = 1'b1;
                sw[2:0] = 3'($urandom);
                sw[8:7] = 2'($urandom);
                rand_stream(110, 85);
                idle(3);
            end
        end

        // Delay change mid-stream: flush starts next cycle, outputs stay dry throughout
        sw[3] = 1'b1;
        rand_stream(200, 100);
        sw[6:4] = 3'd2;
        clr_obs = 0;
        rand_stream(4300, 100);
        check("midstream_clear_len", clr_obs, DEPTH);
        idle(3);

        // Reset with an output pending
        step(1'b1, pack(123456, -654321));
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_pend_out_valid", out_valid, 0);
        check("rst_pend_data_out", data_out, 0);
        check("rst_pend_clip", clip_flag, 0);
        @(negedge clk);
        check("rst_hold_out_valid", out_valid, 0);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        ov_obs = 0;
        idle(20);
        check("post_rst_no_output", ov_obs, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
